// File: rtl/stage_pkg.sv
// Shared types and constants for the ID/EX operand stage.
// Optional feature macro: ALU_FORWARDING_EN (see id_ex_operand_stage.sv).
package stage_pkg;

    // Widths baked into ex_ctrl_t; the top-level parameters must match these.
    localparam int OP_W  = 4;
    localparam int REG_W = 5;

    localparam logic [OP_W-1:0] ALU_AND = 4'b0000;
    localparam logic [OP_W-1:0] ALU_XOR = 4'b0001;
    localparam logic [OP_W-1:0] ALU_SUB = 4'b0010;
    localparam logic [OP_W-1:0] ALU_OR  = 4'b0011;
    localparam logic [OP_W-1:0] ALU_ADD = 4'b0100;
    localparam logic [OP_W-1:0] ALU_EQ  = 4'b1000;
    localparam logic [OP_W-1:0] ALU_SHL = 4'b1001;
    localparam logic [OP_W-1:0] ALU_LUI = 4'b1010;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

    typedef struct packed {
        logic             valid;
        logic             reg_write;
        logic             mem_read;
        logic             mem_write;
        logic             alu_src;
        logic [OP_W-1:0]  alu_op;
        logic [REG_W-1:0] rd;
    } ex_ctrl_t;

    // A bubble: no architectural side effects, rd = x0.
    localparam ex_ctrl_t CTRL_BUBBLE = '{
        valid:     1'b0,
        reg_write: 1'b0,
        mem_read:  1'b0,
        mem_write: 1'b0,
        alu_src:   1'b0,
        alu_op:    ALU_AND,
        rd:        5'd0
    };

endpackage

// File: rtl/forwarding_unit.sv
// Combinational forwarding-source selection for two source registers.
// EX/MEM has priority over MEM/WB because it holds the younger result; x0 never matches.
module forwarding_unit
    import stage_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic                  exmem_reg_write,
    input  logic [REG_ADDR_W-1:0] memwb_rd,
    input  logic                  memwb_reg_write,
    output fwd_sel_e              fwd_a,
    output fwd_sel_e              fwd_b
);

    function automatic fwd_sel_e select_src(
        input logic [REG_ADDR_W-1:0] rs,
        input logic [REG_ADDR_W-1:0] xm_rd,
        input logic                  xm_we,
        input logic [REG_ADDR_W-1:0] wb_rd,
        input logic                  wb_we
    );
        fwd_sel_e sel;
        if (xm_we && (xm_rd != {REG_ADDR_W{1'b0}}) && (xm_rd == rs)) begin
            sel = FWD_EXMEM;
        end else if (wb_we && (wb_rd != {REG_ADDR_W{1'b0}}) && (wb_rd == rs)) begin
            sel = FWD_MEMWB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

    // Pick the youngest in-flight producer for each source operand.
    always_comb begin
        fwd_a = select_src(rs1, exmem_rd, exmem_reg_write, memwb_rd, memwb_reg_write);
        fwd_b = select_src(rs2, exmem_rd, exmem_reg_write, memwb_rd, memwb_reg_write);
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-side operand selection and hazard detection.
// Macro ALU_FORWARDING_EN: defined -> EX/MEM and MEM/WB forwarding with load-use stall;
// undefined (default) -> no forwarding, stall on any RAW against EX, EX/MEM or MEM/WB.
module id_ex_operand_stage
    import stage_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int REG_ADDR_W    = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     id_valid,
    input  logic [REG_ADDR_W-1:0]    id_rs1,
    input  logic [REG_ADDR_W-1:0]    id_rs2,
    input  logic                     id_uses_rs1,
    input  logic                     id_uses_rs2,
    input  logic [REG_ADDR_W-1:0]    id_rd,
    input  logic [DATA_WIDTH-1:0]    id_rs1_data,
    input  logic [DATA_WIDTH-1:0]    id_rs2_data,
    input  logic [DATA_WIDTH-1:0]    id_imm,
    input  logic                     id_alu_src,
    input  logic [OPCODE_LENGTH-1:0] id_alu_op,
    input  logic                     id_reg_write,
    input  logic                     id_mem_read,
    input  logic                     id_mem_write,
    input  logic [DATA_WIDTH-1:0]    id_pc,
    input  logic                     flush,
    input  logic [REG_ADDR_W-1:0]    exmem_rd,
    input  logic                     exmem_reg_write,
    input  logic [DATA_WIDTH-1:0]    exmem_alu_result,
    input  logic [REG_ADDR_W-1:0]    memwb_rd,
    input  logic                     memwb_reg_write,
    input  logic [DATA_WIDTH-1:0]    memwb_wb_data,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     ex_valid,
    output logic                     ex_reg_write,
    output logic                     ex_mem_read,
    output logic                     ex_mem_write,
    output logic [REG_ADDR_W-1:0]    ex_rd,
    output logic [DATA_WIDTH-1:0]    ex_store_data,
    output logic [DATA_WIDTH-1:0]    ex_pc,
    output logic                     hazard_stall
);

    ex_ctrl_t               ex_ctrl_r;
    logic [REG_ADDR_W-1:0]  ex_rs1_r;
    logic [REG_ADDR_W-1:0]  ex_rs2_r;
    logic [DATA_WIDTH-1:0]  ex_rs1_data_r;
    logic [DATA_WIDTH-1:0]  ex_rs2_data_r;
    logic [DATA_WIDTH-1:0]  ex_imm_r;
    logic [DATA_WIDTH-1:0]  ex_pc_r;
    logic [DATA_WIDTH-1:0]  op_a_s;
    logic [DATA_WIDTH-1:0]  op_b_s;
    logic                   hazard_stall_s;
    logic                   ex_rd_nz_s;

    assign ex_rd_nz_s = (ex_ctrl_r.rd != {REG_ADDR_W{1'b0}});

`ifdef ALU_FORWARDING_EN
    fwd_sel_e fwd_a_s;
    fwd_sel_e fwd_b_s;

    forwarding_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd (
        .rs1             (ex_rs1_r),
        .rs2             (ex_rs2_r),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .fwd_a           (fwd_a_s),
        .fwd_b           (fwd_b_s)
    );

    // Forwarding muxes in front of the ALU; they add no pipeline latency.
    always_comb begin
        op_a_s = ex_rs1_data_r;
        op_b_s = ex_rs2_data_r;
        case (fwd_a_s)
            FWD_EXMEM: op_a_s = exmem_alu_result;
            FWD_MEMWB: op_a_s = memwb_wb_data;
            default:   op_a_s = ex_rs1_data_r;
        endcase
        case (fwd_b_s)
            FWD_EXMEM: op_b_s = exmem_alu_result;
            FWD_MEMWB: op_b_s = memwb_wb_data;
            default:   op_b_s = ex_rs2_data_r;
        endcase
    end

    // Only a load in EX cannot be forwarded in time; flush overrides the stall.
    always_comb begin
        hazard_stall_s = 1'b0;
        if (!flush && id_valid && ex_ctrl_r.valid && ex_ctrl_r.mem_read && ex_rd_nz_s &&
            ((id_uses_rs1 && (id_rs1 == ex_ctrl_r.rd)) ||
             (id_uses_rs2 && (id_rs2 == ex_ctrl_r.rd)))) begin
            hazard_stall_s = 1'b1;
        end else begin
            hazard_stall_s = 1'b0;
        end
    end
`else
    fwd_sel_e id_match_a_s;
    fwd_sel_e id_match_b_s;
    logic     ex_writes_s;
    logic     raw_a_s;
    logic     raw_b_s;
    logic     unused_ok_s;

    // Reuse the matcher on the ID sources to find pending writers in EX/MEM and MEM/WB.
    forwarding_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd (
        .rs1             (id_rs1),
        .rs2             (id_rs2),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .fwd_a           (id_match_a_s),
        .fwd_b           (id_match_b_s)
    );

    // Without forwarding the ALU always sees the register-file values captured from ID.
    always_comb begin
        op_a_s = ex_rs1_data_r;
        op_b_s = ex_rs2_data_r;
    end

    // Stall while any used source still has a writer in EX, EX/MEM or MEM/WB.
    always_comb begin
        ex_writes_s    = ex_ctrl_r.valid && ex_ctrl_r.reg_write && ex_rd_nz_s;
        raw_a_s        = id_uses_rs1 && ((id_match_a_s != FWD_RF) ||
                                         (ex_writes_s && (id_rs1 == ex_ctrl_r.rd)));
        raw_b_s        = id_uses_rs2 && ((id_match_b_s != FWD_RF) ||
                                         (ex_writes_s && (id_rs2 == ex_ctrl_r.rd)));
        hazard_stall_s = 1'b0;
        if (!flush && id_valid && (raw_a_s || raw_b_s)) begin
            hazard_stall_s = 1'b1;
        end else begin
            hazard_stall_s = 1'b0;
        end
    end

    // Forwarded data and EX source indices have no consumer in this build.
    assign unused_ok_s = ^{exmem_alu_result, memwb_wb_data, ex_rs1_r, ex_rs2_r};
`endif

    // ID/EX register: reset, flush and stall all load a fully zeroed bubble.
    always_ff @(posedge clk) begin
        if (reset || flush || hazard_stall_s) begin
            ex_ctrl_r     <= CTRL_BUBBLE;
            ex_rs1_r      <= {REG_ADDR_W{1'b0}};
            ex_rs2_r      <= {REG_ADDR_W{1'b0}};
            ex_rs1_data_r <= {DATA_WIDTH{1'b0}};
            ex_rs2_data_r <= {DATA_WIDTH{1'b0}};
            ex_imm_r      <= {DATA_WIDTH{1'b0}};
            ex_pc_r       <= {DATA_WIDTH{1'b0}};
        end else begin
            ex_ctrl_r     <= '{valid:     id_valid,
                               reg_write: id_reg_write,
                               mem_read:  id_mem_read,
                               mem_write: id_mem_write,
                               alu_src:   id_alu_src,
                               alu_op:    id_alu_op,
                               rd:        id_rd};
            ex_rs1_r      <= id_rs1;
            ex_rs2_r      <= id_rs2;
            ex_rs1_data_r <= id_rs1_data;
            ex_rs2_data_r <= id_rs2_data;
            ex_imm_r      <= id_imm;
            ex_pc_r       <= id_pc;
        end
    end

    assign SrcA          = op_a_s;
    assign SrcB          = ex_ctrl_r.alu_src ? ex_imm_r : op_b_s;
    assign ex_store_data = op_b_s;
    assign Operation     = ex_ctrl_r.alu_op;
    assign ex_valid      = ex_ctrl_r.valid;
    assign ex_reg_write  = ex_ctrl_r.reg_write;
    assign ex_mem_read   = ex_ctrl_r.mem_read;
    assign ex_mem_write  = ex_ctrl_r.mem_write;
    assign ex_rd         = ex_ctrl_r.rd;
    assign ex_pc         = ex_pc_r;
    assign hazard_stall  = hazard_stall_s;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: directed vector table plus a
// randomized run against a behavioural model. Expectations follow ALU_FORWARDING_EN.
module tb_id_ex_operand_stage;
    import stage_pkg::*;

`ifdef ALU_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk;
    logic        reset, id_valid, id_uses_rs1, id_uses_rs2, id_alu_src;
    logic        id_reg_write, id_mem_read, id_mem_write, flush;
    logic [4:0]  id_rs1, id_rs2, id_rd, exmem_rd, memwb_rd, ex_rd;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
    logic [3:0]  id_alu_op, Operation;
    logic        exmem_reg_write, memwb_reg_write;
    logic [31:0] exmem_alu_result, memwb_wb_data;
    logic [31:0] SrcA, SrcB, ex_store_data, ex_pc;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, hazard_stall;

    int errors = 0;
    int checks = 0;

    id_ex_operand_stage dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_alu_src(id_alu_src), .id_alu_op(id_alu_op),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_pc(id_pc), .flush(flush),
        .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_alu_result(exmem_alu_result),
        .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_wb_data(memwb_wb_data),
        .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_rd(ex_rd), .ex_store_data(ex_store_data),
        .ex_pc(ex_pc), .hazard_stall(hazard_stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic        rst, flush, hold, chk;
        logic        idv;
        logic [4:0]  rs1, rs2, rd;
        logic        u1, u2;
        logic [31:0] d1, d2, imm, pc;
        logic        asrc;
        logic [3:0]  op;
        logic        rw, mr, mw;
        logic [4:0]  xm_rd;
        logic        xm_w;
        logic [31:0] xm_res;
        logic [4:0]  wb_rd;
        logic        wb_w;
        logic [31:0] wb_data;
        logic [31:0] e_a, e_b, e_st;
        logic [3:0]  e_op;
        logic        e_v, e_rw;
        logic [4:0]  e_rd;
        logic        e_stall;
    } vec_t;

    // Instruction currently held in EX, as the model sees it.
    typedef struct packed {
        logic        v, rw, mr, mw, asrc;
        logic [3:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] d1, d2, imm, pc;
    } ex_m_t;

    function automatic vec_t op_add(input vec_t v, input logic [4:0] rd, input logic [4:0] rs1,
                                    input logic [4:0] rs2, input logic [31:0] d1, input logic [31:0] d2);
        v.idv = 1'b1; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.u1 = 1'b1; v.u2 = 1'b1;
        v.d1 = d1; v.d2 = d2; v.op = ALU_ADD; v.rw = 1'b1;
        return v;
    endfunction

    function automatic vec_t op_lw(input vec_t v, input logic [4:0] rd, input logic [4:0] rs1,
                                   input logic [31:0] d1, input logic [31:0] imm);
        v.idv = 1'b1; v.rd = rd; v.rs1 = rs1; v.u1 = 1'b1; v.d1 = d1; v.imm = imm;
        v.asrc = 1'b1; v.op = ALU_ADD; v.rw = 1'b1; v.mr = 1'b1;
        return v;
    endfunction

    function automatic vec_t expect_ex(input vec_t v, input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] st, input logic [3:0] op, input logic ev,
                                       input logic erw, input logic [4:0] erd, input logic stall);
        v.chk = 1'b1; v.e_a = a; v.e_b = b; v.e_st = st; v.e_op = op;
        v.e_v = ev; v.e_rw = erw; v.e_rd = erd; v.e_stall = stall;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        reset = v.rst; flush = v.flush; id_valid = v.idv;
        id_rs1 = v.rs1; id_rs2 = v.rs2; id_rd = v.rd;
        id_uses_rs1 = v.u1; id_uses_rs2 = v.u2;
        id_rs1_data = v.d1; id_rs2_data = v.d2; id_imm = v.imm; id_pc = v.pc;
        id_alu_src = v.asrc; id_alu_op = v.op;
        id_reg_write = v.rw; id_mem_read = v.mr; id_mem_write = v.mw;
        exmem_rd = v.xm_rd; exmem_reg_write = v.xm_w; exmem_alu_result = v.xm_res;
        memwb_rd = v.wb_rd; memwb_reg_write = v.wb_w; memwb_wb_data = v.wb_data;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Reference: value delivered for a source register given the bypass buses.
    function automatic logic [31:0] fwd_val(input logic [4:0] rs, input logic [31:0] rf, input vec_t v);
        if (FWD && v.xm_w && v.xm_rd != 5'd0 && v.xm_rd == rs) return v.xm_res;
        if (FWD && v.wb_w && v.wb_rd != 5'd0 && v.wb_rd == rs) return v.wb_data;
        return rf;
    endfunction

    // Reference: a used source still has an uncommitted writer anywhere downstream.
    function automatic logic raw_any(input logic [4:0] rs, input logic u, input ex_m_t m, input vec_t v);
        if (!u || rs == 5'd0) return 1'b0;
        return (m.v && m.rw && m.rd == rs) || (v.xm_w && v.xm_rd == rs) || (v.wb_w && v.wb_rd == rs);
    endfunction

    function automatic logic model_stall(input ex_m_t m, input vec_t v);
        logic load_use;
        load_use = m.v && m.mr && m.rd != 5'd0 &&
                   ((v.u1 && v.rs1 == m.rd) || (v.u2 && v.rs2 == m.rd));
        if (v.flush || !v.idv) return 1'b0;
        return FWD ? load_use : (raw_any(v.rs1, v.u1, m, v) || raw_any(v.rs2, v.u2, m, v));
    endfunction

    vec_t  vt[$];
    vec_t  z, r, v;
    ex_m_t m;

    initial begin
        z = '0;
        // r0/r1: reset held two cycles with a real instruction in ID
        r = op_add(z, 5'd3, 5'd1, 5'd2, 32'd5, 32'd7); r.rst = 1'b1; vt.push_back(r);
        r = expect_ex(op_add(z, 5'd3, 5'd1, 5'd2, 32'd5, 32'd7), 32'h0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 5'd0, 1'b0);
        r.rst = 1'b1; vt.push_back(r);
        // r2: first post-reset edge captures add x3,x1,x2
        r = expect_ex(op_add(z, 5'd3, 5'd1, 5'd2, 32'd5, 32'd7), 32'h0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 5'd0, 1'b0);
        vt.push_back(r);
        // r3: add x3 in EX; ID add x7,x1,x2
        r = expect_ex(op_add(z, 5'd7, 5'd1, 5'd2, 32'd9, 32'd2), 32'd5, 32'd7, 32'd7, ALU_ADD, 1'b1, 1'b1, 5'd3, 1'b0);
        vt.push_back(r);
        // r4..r6: same EX instruction, bypass buses varied without a clock
        r = expect_ex(z, FWD ? 32'h10 : 32'h9, 32'h2, 32'h2, ALU_ADD, 1'b1, 1'b1, 5'd7, 1'b0);
        r.hold = 1'b1; r.xm_rd = 5'd1; r.xm_w = 1'b1; r.xm_res = 32'h10;
        r.wb_rd = 5'd1; r.wb_w = 1'b1; r.wb_data = 32'h20; vt.push_back(r);
        r.xm_w = 1'b0; r.e_a = FWD ? 32'h20 : 32'h9; vt.push_back(r);
        r.xm_w = 1'b1; r.xm_rd = 5'd0; r.wb_rd = 5'd0; r.e_a = 32'h9; r.hold = 1'b0; vt.push_back(r);
        // r7: lw x4,4(x2) enters
        r = expect_ex(op_lw(z, 5'd4, 5'd2, 32'h100, 32'h4), 32'h0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 5'd0, 1'b0);
        vt.push_back(r);
        // r8: add x5,x4,x6 behind the load -> stall
        r = expect_ex(op_add(z, 5'd5, 5'd4, 5'd6, 32'hdead, 32'h3), 32'h100, 32'h4, 32'h0, ALU_ADD, 1'b1, 1'b1, 5'd4, 1'b1);
        vt.push_back(r);
        // r9: bubble in EX, load in EX/MEM
        r = expect_ex(op_add(z, 5'd5, 5'd4, 5'd6, 32'hdead, 32'h3), 32'h0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 5'd0, !FWD);
        r.xm_rd = 5'd4; r.xm_w = 1'b1; r.xm_res = 32'h104; vt.push_back(r);
        // r10: load in MEM/WB
        r = expect_ex(op_add(z, 5'd5, 5'd4, 5'd6, 32'hdead, 32'h3), FWD ? 32'h55 : 32'h0, FWD ? 32'h3 : 32'h0,
                      FWD ? 32'h3 : 32'h0, FWD ? ALU_ADD : ALU_AND, FWD, FWD, FWD ? 5'd5 : 5'd0, !FWD);
        r.wb_rd = 5'd4; r.wb_w = 1'b1; r.wb_data = 32'h55; vt.push_back(r);
        // r11: buses quiet
        r = expect_ex(op_add(z, 5'd5, 5'd4, 5'd6, 32'hdead, 32'h3), FWD ? 32'hdead : 32'h0, FWD ? 32'h3 : 32'h0,
                      FWD ? 32'h3 : 32'h0, FWD ? ALU_ADD : ALU_AND, FWD, FWD, FWD ? 5'd5 : 5'd0, 1'b0);
        vt.push_back(r);
        // r12: add now in EX in both builds
        r = expect_ex(z, 32'hdead, 32'h3, 32'h3, ALU_ADD, 1'b1, 1'b1, 5'd5, 1'b0); vt.push_back(r);
        // r13/r14: load-use together with flush -> no stall, bubble
        r = expect_ex(op_lw(z, 5'd4, 5'd2, 32'h100, 32'h4), 32'h0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 5'd0, 1'b0);
        vt.push_back(r);
        r = expect_ex(op_add(z, 5'd5, 5'd4, 5'd6, 32'hdead, 32'h3), 32'h100, 32'h4, 32'h0, ALU_ADD, 1'b1, 1'b1, 5'd4, 1'b0);
        r.flush = 1'b1; vt.push_back(r);
        r = expect_ex(z, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 5'd0, 1'b0); vt.push_back(r);
        // r16: lui x8
        r = expect_ex(z, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 5'd0, 1'b0);
        r.idv = 1'b1; r.rd = 5'd8; r.asrc = 1'b1; r.imm = 32'h12345000; r.op = ALU_LUI; r.rw = 1'b1;
        vt.push_back(r);
        // r17: sw x9,8(x10)
        r = expect_ex(z, 32'h0, 32'h12345000, 32'h0, ALU_LUI, 1'b1, 1'b1, 5'd8, 1'b0);
        r.idv = 1'b1; r.rs1 = 5'd10; r.rs2 = 5'd9; r.u1 = 1'b1; r.u2 = 1'b1; r.d1 = 32'h200;
        r.d2 = 32'h11; r.imm = 32'h8; r.asrc = 1'b1; r.mw = 1'b1; r.op = ALU_ADD; vt.push_back(r);
        // r18: store in EX, x9 produced by EX/MEM
        r = expect_ex(z, 32'h200, 32'h8, FWD ? 32'hAB : 32'h11, ALU_ADD, 1'b1, 1'b0, 5'd0, 1'b0);
        r.xm_rd = 5'd9; r.xm_w = 1'b1; r.xm_res = 32'hAB; vt.push_back(r);

        @(negedge clk);
        for (int i = 0; i < vt.size(); i++) begin
            v = vt[i];
            v.pc = 32'h1000 + 32'(i * 4);
            drive(v);
            #1;
            if (v.chk) begin
                check($sformatf("row%0d SrcA", i), SrcA, v.e_a);
                check($sformatf("row%0d SrcB", i), SrcB, v.e_b);
                check($sformatf("row%0d store_data", i), ex_store_data, v.e_st);
                check($sformatf("row%0d Operation", i), 32'(Operation), 32'(v.e_op));
                check($sformatf("row%0d ex_valid", i), 32'(ex_valid), 32'(v.e_v));
                check($sformatf("row%0d ex_reg_write", i), 32'(ex_reg_write), 32'(v.e_rw));
                check($sformatf("row%0d ex_rd", i), 32'(ex_rd), 32'(v.e_rd));
                check($sformatf("row%0d hazard_stall", i), 32'(hazard_stall), 32'(v.e_stall));
            end
            if (!v.hold) @(negedge clk);
        end

        // Randomized run; a small register range keeps hazards and matches frequent.
        m = '0;
        for (int k = 0; k < 400; k++) begin
            logic        stall_e;
            logic [31:0] b_e;
            r = '0;
            r.rst     = (k == 0) || ($urandom_range(0, 63) == 0);
            r.flush   = ($urandom_range(0, 7) == 0);
            r.idv     = ($urandom_range(0, 3) != 0);
            r.rs1     = 5'($urandom_range(0, 3));
            r.rs2     = 5'($urandom_range(0, 3));
            r.rd      = 5'($urandom_range(0, 3));
            r.u1      = 1'($urandom_range(0, 1));
            r.u2      = 1'($urandom_range(0, 1));
            r.d1      = $urandom;
            r.d2      = $urandom;
            r.imm     = $urandom;
            r.pc      = $urandom;
            r.asrc    = 1'($urandom_range(0, 1));
            r.op      = 4'($urandom_range(0, 15));
            r.rw      = 1'($urandom_range(0, 1));
            r.mr      = ($urandom_range(0, 2) == 0);
            r.mw      = 1'($urandom_range(0, 1));
            r.xm_rd   = 5'($urandom_range(0, 3));
            r.xm_w    = 1'($urandom_range(0, 1));
            r.xm_res  = $urandom;
            r.wb_rd   = 5'($urandom_range(0, 3));
            r.wb_w    = 1'($urandom_range(0, 1));
            r.wb_data = $urandom;
            drive(r);
            #1;
            stall_e = model_stall(m, r);
            if (k > 0) begin
                b_e = fwd_val(m.rs2, m.d2, r);
                check($sformatf("rnd%0d SrcA", k), SrcA, fwd_val(m.rs1, m.d1, r));
                check($sformatf("rnd%0d SrcB", k), SrcB, m.asrc ? m.imm : b_e);
                check($sformatf("rnd%0d store_data", k), ex_store_data, b_e);
                check($sformatf("rnd%0d Operation", k), 32'(Operation), 32'(m.op));
                check($sformatf("rnd%0d ex_valid", k), 32'(ex_valid), 32'(m.v));
                check($sformatf("rnd%0d ex_reg_write", k), 32'(ex_reg_write), 32'(m.rw));
                check($sformatf("rnd%0d ex_mem_read", k), 32'(ex_mem_read), 32'(m.mr));
                check($sformatf("rnd%0d ex_mem_write", k), 32'(ex_mem_write), 32'(m.mw));
                check($sformatf("rnd%0d ex_rd", k), 32'(ex_rd), 32'(m.rd));
                check($sformatf("rnd%0d ex_pc", k), ex_pc, m.pc);
                check($sformatf("rnd%0d hazard_stall", k), 32'(hazard_stall), 32'(stall_e));
            end
            // Advance the model: anything but a normal capture leaves an empty EX slot.
            if (r.rst || r.flush || stall_e) begin
                m = '0;
            end else begin
                m.v = r.idv; m.rw = r.rw; m.mr = r.mr; m.mw = r.mw; m.asrc = r.asrc;
                m.op = r.op; m.rd = r.rd; m.rs1 = r.rs1; m.rs2 = r.rs2;
                m.d1 = r.d1; m.d2 = r.d2; m.imm = r.imm; m.pc = r.pc;
            end
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
